fifo_stream_reader: RTL and testbench

- Downstream stage for the flip-flop FIFO with empty/full outputs. It pops the FIFO's show-ahead read port and presents the data as a registered valid/ready stream to the consumer.
- A 2-entry output buffer keeps out_valid and out_data straight from flops. The pop request depends only on this block's own state and fifo_empty, never on out_ready.
- Full throughput: one beat per cycle in steady state.

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 tb/tb_fifo_stream_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pops a show-ahead FIFO and re-presents its words as a registered valid/ready stream.
// A two-entry skid buffer lets the pop request ignore out_ready while keeping full throughput.
module fifo_stream_reader #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_read_data,
    output logic                 fifo_pop,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [cnt_width-1:0] beat_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [width-1:0] head, head_next;
    logic [width-1:0] tail, tail_next;
    logic             take;

    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign occupancy = state;
    assign take      = out_valid & out_ready;

    // Gating with rst_n keeps the FIFO from advancing while this block is held in reset.
    assign fifo_pop = rst_n & ~fifo_empty & ~flush & (state != FULL);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fifo_pop) begin
                        head_next  = fifo_read_data;
                        state_next = HALF;
                    end
                end
                HALF: begin
                    if (fifo_pop && take) begin
                        head_next = fifo_read_data;
                    end else if (fifo_pop) begin
                        tail_next  = fifo_read_data;
                        state_next = FULL;
                    end else if (take) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        head_next  = tail;
                        state_next = HALF;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: head and tail are datapath registers but are cleared on reset so out_data reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            head       <= '0;
            tail       <= '0;
            beat_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            if (take) begin
                beat_count <= beat_count + cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO stub feeds the DUT and a
// scoreboard of buffered words predicts the stream, occupancy and beat count.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_read_data;
    logic        fifo_pop;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  occupancy;
    logic [15:0] beat_count;

    logic        pop4, valid4;
    logic [7:0]  data4;
    logic [1:0]  occ4;
    logic [3:0]  beat_count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.width(8), .cnt_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy), .beat_count(beat_count)
    );

    fifo_stream_reader #(.width(8), .cnt_width(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(pop4), .flush(flush), .out_valid(valid4), .out_ready(out_ready),
        .out_data(data4), .occupancy(occ4), .beat_count(beat_count4)
    );

    // Upstream FIFO stub: written by the stimulus, read pointer advanced by the DUT's pop.
    logic [7:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty     = (rd_ptr == wr_ptr);
    assign fifo_read_data = mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 1;
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference model: a queue of buffered words (oldest first), at most two deep.
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];
    int beats = 0;
    int dut_pops = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            obs.delete();
            beats    = 0;
            dut_pops = 0;
        end else begin
            automatic bit m_take = (exp_q.size() != 0) && out_ready;
            automatic bit m_pop  = !fifo_empty && !flush && (exp_q.size() < 2);
            automatic logic [7:0] in_word = fifo_read_data;
            if (fifo_pop) dut_pops++;
            if (m_take) begin
                obs.push_back(out_data);
                void'(exp_q.pop_front());
                beats++;
            end
            if (flush) exp_q.delete();
            if (m_pop) exp_q.push_back(in_word);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        wr_ptr    = rd_ptr;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        push(8'hAA);
        repeat (2) @(negedge clk);
        checks++; if (fifo_pop !== 1'b0)   begin errors++; $display("FAIL rst_pop: got %0b want 0", fifo_pop); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0)  begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL rst_beats: got %0d want 0", beat_count); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h want 00", out_data); end
        wr_ptr = rd_ptr;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({fifo_pop, out_valid, occupancy, beat_count} !== 20'd0)
            begin errors++; $display("FAIL idle: pop=%0b valid=%0b occ=%0d beats=%0d want all 0", fifo_pop, out_valid, occupancy, beat_count); end
    endtask

    task automatic test_streaming();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        out_ready = 1'b1;
        foreach (seq[i]) push(seq[i]);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== seq[i])
                begin errors++; $display("FAIL stream_beat%0d: valid=%0b data=%h want 1/%h", i, out_valid, out_data, seq[i]); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            begin errors++; $display("FAIL stream_drain: valid=%0b occ=%0d want 0/0", out_valid, occupancy); end
        checks++; if (beat_count !== 16'd4) begin errors++; $display("FAIL stream_count: got %0d want 4", beat_count); end
        checks++; if (obs.size() != 4 || obs[0] !== 8'h11 || obs[3] !== 8'h44)
            begin errors++; $display("FAIL stream_order: got %0d beats want 11..44", obs.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        repeat (5) @(negedge clk);
        checks++; if (dut_pops != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", dut_pops); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11)
            begin errors++; $display("FAIL bp_hold: valid=%0b data=%h want 1/11", out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== seq[i])
                begin errors++; $display("FAIL bp_beat%0d: valid=%0b data=%h want 1/%h", i, out_valid, out_data, seq[i]); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0 || beat_count !== 16'd4)
            begin errors++; $display("FAIL bp_end: valid=%0b beats=%0d want 0/4", out_valid, beat_count); end
    endtask

    task automatic test_flush();
        do_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (3) @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre_occ: got %0d want 2", occupancy); end
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL fl_pop: got %0b want 0", fifo_pop); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL fl_occ: occ=%0d valid=%0b want 0/0", occupancy, out_valid); end
        checks++; if (beat_count !== 16'd1) begin errors++; $display("FAIL fl_count: got %0d want 1", beat_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h33)
            begin errors++; $display("FAIL fl_resume: valid=%0b data=%h want 1/33", out_valid, out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h44)
            begin errors++; $display("FAIL fl_next: valid=%0b data=%h want 1/44", out_valid, out_data); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i + 8'h50));
        repeat (22) @(negedge clk);
        checks++; if (beat_count4 !== 4'd1) begin errors++; $display("FAIL wrap4: got %0d want 1", beat_count4); end
        checks++; if (beat_count !== 16'd17) begin errors++; $display("FAIL wrap16: got %0d want 17", beat_count); end
    endtask

    task automatic test_random();
        int ready_bias;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            automatic bit exp_pop;
            ready_bias = (c < 200) ? 7 : 3;
            if ($urandom_range(0, 9) < 6) push(8'($urandom));
            out_ready = ($urandom_range(0, 9) < ready_bias);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            exp_pop = !fifo_empty && !flush && (exp_q.size() < 2);
            checks++; if (fifo_pop !== exp_pop)
                begin errors++; $display("FAIL rnd_pop c%0d: got %0b want %0b", c, fifo_pop, exp_pop); end
            @(negedge clk);
            checks++; if (occupancy !== 2'(exp_q.size()) || out_valid !== (exp_q.size() != 0))
                begin errors++; $display("FAIL rnd_occ c%0d: occ=%0d valid=%0b want %0d", c, occupancy, out_valid, exp_q.size()); end
            if (exp_q.size() != 0) begin
                checks++; if (out_data !== exp_q[0])
                    begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data, exp_q[0]); end
            end
            checks++; if (beat_count !== 16'(beats) || beat_count4 !== 4'(beats))
                begin errors++; $display("FAIL rnd_count c%0d: got %0d/%0d want %0d", c, beat_count, beat_count4, beats); end
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        push(8'h61); push(8'h62); push(8'h63);
        repeat (3) @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_pre_occ: got %0d want 2", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            begin errors++; $display("FAIL ar_clear: valid=%0b occ=%0d want 0/0", out_valid, occupancy); end
        checks++; if (fifo_pop !== 1'b0 || beat_count !== 16'd0)
            begin errors++; $display("FAIL ar_pop: pop=%0b beats=%0d want 0/0", fifo_pop, beat_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
